// File: rtl/inst_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_mem_pkg : shared constants and loader state type for inst_mem (rev 1.0)
// ---------------------------------------------------------------------------
package inst_mem_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned INST_WIDTH_DEF = 32;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;

  typedef enum logic [0:0] {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_loader : byte-serial word assembler and write-pointer FSM (rev 1.0)
// ---------------------------------------------------------------------------
module inst_loader
  import inst_mem_pkg::*;
#(
  parameter int unsigned INST_WIDTH  = INST_WIDTH_DEF,
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS),
  localparam int unsigned CNT_W = IDX_W + 1,
  localparam int unsigned BPW   = INST_WIDTH / 8,
  localparam int unsigned BC_W  = $clog2(BPW)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ld_start_i,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_done_i,
  output logic                  ld_busy_o,
  output logic                  ld_ovf_o,
  output logic [CNT_W-1:0]      ld_words_o,
  output logic                  we_o,
  output logic [IDX_W-1:0]      waddr_o,
  output logic [INST_WIDTH-1:0] wdata_o
);

  ld_state_e               state_q, state_d;
  logic [BC_W-1:0]         cnt_q, cnt_d;
  logic [INST_WIDTH-1:0]   word_q, word_d;
  logic [CNT_W-1:0]        wptr_q, wptr_d;
  logic                    ovf_q, ovf_d;
  logic [INST_WIDTH-1:0]   asm_word;
  logic [BC_W:0]           fill;
  logic                    we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LD_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wptr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wptr_q  <= wptr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    wptr_d   = wptr_q;
    ovf_d    = ovf_q;
    asm_word = word_q;
    fill     = {1'b0, cnt_q};
    we       = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (ld_start_i) begin
          state_d = LD_LOAD;
          cnt_d   = '0;
          word_d  = '0;
          wptr_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      LD_LOAD: begin
        if (ld_start_i) begin
          cnt_d  = '0;
          word_d = '0;
          wptr_d = '0;
          ovf_d  = 1'b0;
        end else begin
          // The byte of this cycle lands first; a flush then pads the rest with zeros.
          if (ld_valid_i) begin
            asm_word[{cnt_q, 3'b000} +: 8] = ld_byte_i;
            fill = fill + (BC_W+1)'(1);
          end
          if ((fill == BPW[BC_W:0]) || (ld_done_i && (fill != '0))) begin
            cnt_d  = '0;
            word_d = '0;
            if (wptr_q == DEPTH_WORDS[CNT_W-1:0]) begin
              ovf_d = 1'b1;
            end else begin
              we     = 1'b1;
              wptr_d = wptr_q + CNT_W'(1);
            end
          end else begin
            cnt_d  = fill[BC_W-1:0];
            word_d = asm_word;
          end
          if (ld_done_i) begin
            state_d = LD_IDLE;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  assign ld_busy_o  = (state_q == LD_LOAD);
  assign ld_ovf_o   = ovf_q;
  assign ld_words_o = wptr_q;
  assign we_o       = we;
  assign waddr_o    = wptr_q[IDX_W-1:0];
  assign wdata_o    = asm_word;

endmodule
`default_nettype wire

// File: rtl/inst_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_mem : registered instruction memory with byte-serial loader (rev 1.0)
// ---------------------------------------------------------------------------
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned           INST_WIDTH  = INST_WIDTH_DEF,
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS),
  localparam int unsigned CNT_W = IDX_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  inst_valid_o,
  output logic                  fetch_err_o,
  input  logic                  ld_start_i,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_done_i,
  output logic                  ld_busy_o,
  output logic                  ld_ovf_o,
  output logic [CNT_W-1:0]      ld_words_o
);

  logic                  we;
  logic [IDX_W-1:0]      waddr;
  logic [INST_WIDTH-1:0] wdata;
  logic [INST_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [ADDR_WIDTH:0]   diff;
  logic                  in_range;
  logic                  aligned;
  logic [IDX_W-1:0]      ridx;

  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  inst_loader #(
    .INST_WIDTH  (INST_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_loader (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ld_start_i (ld_start_i),
    .ld_valid_i (ld_valid_i),
    .ld_byte_i  (ld_byte_i),
    .ld_done_i  (ld_done_i),
    .ld_busy_o  (ld_busy_o),
    .ld_ovf_o   (ld_ovf_o),
    .ld_words_o (ld_words_o),
    .we_o       (we),
    .waddr_o    (waddr),
    .wdata_o    (wdata)
  );

  // Contents are deliberately outside reset so a core reset keeps the loaded image.
  always_ff @(posedge clk_i) begin
    if (we && !rst_i) begin
      mem[waddr] <= wdata;
    end
  end

  // The borrow bit of the subtraction flags addresses below BASE_ADDR (BASE_ADDR is word-aligned).
  assign diff     = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign aligned  = (diff[1:0] == 2'b00);
  assign in_range = !diff[ADDR_WIDTH] && (diff[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign ridx     = diff[IDX_W+1:2];

  always_comb begin
    inst_d  = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (ld_busy_o || ld_start_i) begin
      inst_d = INST_WIDTH'(INST_NOP);
    end else if (ce_i) begin
      valid_d = 1'b1;
      if (aligned && in_range) begin
        inst_d = mem[ridx];
      end else begin
        inst_d = INST_WIDTH'(INST_NOP);
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign fetch_err_o  = err_q;

endmodule
`default_nettype wire
